// File: rtl/reg_bank.sv
// reg_bank: indexed register bank with per-register load, clear and wrap-around increment, plus a registered read port with write forwarding
//
// Parameters: WIDTH (data width), NUM_REGS (2..2^SEL_W registers), SEL_W (select width)
// Ports:
//   clk      - clock; all state changes on the falling edge
//   reset    - asynchronous, active-low reset
//   op       - 00 nop, 01 load, 10 clear, 11 increment, applied to regs[load_sel]
//   load_sel - target register of op
//   data_in  - load data
//   limit_in - increment wrap limit
//   rd_sel   - read register index
//   bus_out  - registered read data, forwarded from the same-edge write
//   wrap     - one-cycle pulse when an increment hit limit_in and wrapped to 0
//   err      - one-cycle pulse when op or rd_sel addressed a non-existent register
// Configuration: define REG_BANK_INC_EN to enable op 11 increment; otherwise op 11 is a nop and wrap is 0.
module reg_bank #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       op,
  input  logic [SEL_W-1:0] load_sel,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] limit_in,
  input  logic [SEL_W-1:0] rd_sel,
  output logic [WIDTH-1:0] bus_out,
  output logic             wrap,
  output logic             err
);
  logic [WIDTH-1:0] regs [NUM_REGS];
  logic [WIDTH-1:0] cur, rd_val, nv;
  logic ld_ok, rd_ok, act, wrap_d;
  assign ld_ok = 32'(load_sel) < NUM_REGS;
  assign rd_ok = 32'(rd_sel) < NUM_REGS;
  always_comb begin
    cur = '0;
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(load_sel) == i) cur = regs[i];
      if (32'(rd_sel) == i) rd_val = regs[i];
    end
  end
`ifdef REG_BANK_INC_EN
  logic hit;
  assign hit = cur == limit_in;
  assign act = op != 2'b00;
  assign nv = op == 2'b01 ? data_in : (op == 2'b11 && !hit) ? cur + WIDTH'(1) : '0;
  assign wrap_d = op == 2'b11 && ld_ok && hit;
`else
  logic unused_limit;
  assign unused_limit = ^limit_in;
  assign act = op == 2'b01 || op == 2'b10;
  assign nv = op == 2'b01 ? data_in : '0;
  assign wrap_d = 1'b0;
`endif
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      bus_out <= '0;
      wrap <= 1'b0;
      err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) if (act && 32'(load_sel) == i) regs[i] <= nv;
      bus_out <= !rd_ok ? '0 : (act && rd_sel == load_sel) ? nv : rd_val;
      wrap <= wrap_d;
      err <= (act && !ld_ok) || !rd_ok;
    end
  end
endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: randomized scoreboard bench for reg_bank against an array-based reference model
module tb_reg_bank;
  localparam int N = 6;
`ifdef REG_BANK_INC_EN
  localparam bit INC = 1'b1;
`else
  localparam bit INC = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0;
  logic [1:0] op = '0;
  logic [2:0] load_sel = '0, rd_sel = '0;
  logic [15:0] data_in = '0, limit_in = '0, bus_out;
  logic wrap, err;
  typedef struct { logic [15:0] b; logic w; logic e; } exp_t;
  exp_t q[$];
  logic [15:0] m [N];
  int n_vec = 0, n_err = 0;

  reg_bank #(.WIDTH(16), .NUM_REGS(N), .SEL_W(3)) dut (
    .clk(clk), .reset(reset), .op(op), .load_sel(load_sel), .data_in(data_in),
    .limit_in(limit_in), .rd_sel(rd_sel), .bus_out(bus_out), .wrap(wrap), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m[i] = '0;
  endtask

  task automatic step(input logic [1:0] o, input logic [2:0] ls, input logic [15:0] d,
                      input logic [15:0] lim, input logic [2:0] rs);
    exp_t e;
    @(posedge clk);
    op = o; load_sel = ls; data_in = d; limit_in = lim; rd_sel = rs;
    e.w = 1'b0;
    e.e = 1'b0;
    if (o == 2'd1 || o == 2'd2 || (o == 2'd3 && INC)) begin
      if (int'(ls) >= N) e.e = 1'b1;
      else if (o == 2'd1) m[ls] = d;
      else if (o == 2'd2) m[ls] = '0;
      else if (m[ls] == lim) begin m[ls] = '0; e.w = 1'b1; end
      else m[ls] = m[ls] + 16'd1;
    end
    if (int'(rs) >= N) begin e.b = '0; e.e = 1'b1; end
    else e.b = m[rs];
    q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    #2;
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
      q.delete();
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (reset && q.size() != 0) begin
        e = q.pop_front();
        chk("bus_out", bus_out, e.b);
        chk("wrap", 16'(wrap), 16'(e.w));
        chk("err", 16'(err), 16'(e.e));
      end
    end
  end

  initial begin : stim
    logic [2:0] ls;
    #1;
    chk("rst_bus", bus_out, 16'h0);
    chk("rst_wrap", 16'(wrap), 16'h0);
    chk("rst_err", 16'(err), 16'h0);
    model_reset();
    #11 reset = 1'b1;
    step(2'd1, 3'd3, 16'h00A3, 16'h0, 3'd0);
    step(2'd1, 3'd5, 16'h1234, 16'h0, 3'd5);
    step(2'd1, 3'd3, 16'h5555, 16'h0, 3'd3);
    step(2'd1, 3'd5, 16'h7777, 16'h0, 3'd3);
    step(2'd2, 3'd1, 16'h0, 16'h0, 3'd1);
    for (int i = 0; i < 5; i++) step(2'd3, 3'd1, 16'h0, 16'd3, 3'd1);
    step(2'd0, 3'd0, 16'h0, 16'd3, 3'd1);
    step(2'd1, 3'd0, 16'hFFFF, 16'h0, 3'd0);
    step(2'd3, 3'd0, 16'h0, 16'h0010, 3'd0);
    step(2'd1, 3'd7, 16'hDEAD, 16'h0, 3'd5);
    step(2'd0, 3'd0, 16'h0, 16'h0, 3'd6);
    step(2'd3, 3'd6, 16'h0, 16'h0, 3'd2);
    step(2'd1, 3'd4, 16'h0007, 16'h0, 3'd4);
    for (int i = 0; i < 3; i++) step(2'd3, 3'd4, 16'h0, 16'h0, 3'd4);
    for (int i = 0; i < 400; i++) begin
      ls = 3'($urandom_range(0, 7));
      step(2'($urandom), ls, 16'($urandom),
           ($urandom_range(0, 2) == 0 && int'(ls) < N) ? m[ls] : 16'($urandom_range(0, 3)),
           3'($urandom_range(0, 7)));
    end
    step(2'd1, 3'd2, 16'hBEEF, 16'h0, 3'd2);
    drain();
    @(posedge clk);
    op = 2'd1; load_sel = 3'd2; data_in = 16'h1111; rd_sel = 3'd2;
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_bus", bus_out, 16'h0);
    chk("mid_rst_wrap", 16'(wrap), 16'h0);
    chk("mid_rst_err", 16'(err), 16'h0);
    model_reset();
    @(negedge clk);
    #1;
    chk("hold_rst_bus", bus_out, 16'h0);
    #1 reset = 1'b1;
    for (int i = 0; i < N; i++) step(2'd0, 3'd0, 16'h0, 16'h0, 3'(i));
    step(2'd1, 3'd2, 16'h4242, 16'h0, 3'd2);
    step(2'd0, 3'd0, 16'h0, 16'h0, 3'd2);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
